katadc_snapshot: RTL and testbench

//  Triggered snapshot capture of KAT ADC output words, one write per user_data_valid cycle,

---
 rtl/katadc_snapshot_pkg.sv | 41 ++++
 rtl/katadc_snap_ram.sv | 35 +++
 rtl/katadc_snapshot.sv | 152 +++++++++++++++
 tb/tb_katadc_snapshot.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/katadc_snapshot_pkg.sv
// Shared definitions for the KAT ADC snapshot block: FSM encoding, word layout
// and small combinational helpers.
package katadc_snapshot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } snap_state_t;

   localparam int LANES  = 4;
   localparam int BYTE_W = 8;
   localparam int I_BASE = 0;
   localparam int Q_BASE = 32;

   // I lanes fill the low half, Q lanes the high half, lane 0 in the lowest byte
   function automatic logic [63:0] pack_word(input logic [3:0][7:0] i_s,
                                             input logic [3:0][7:0] q_s);
      logic [63:0] w_s;
      w_s = 64'd0;
      for (int n = 0; n < LANES; n++) begin
         w_s[I_BASE + n*BYTE_W +: BYTE_W] = i_s[n];
         w_s[Q_BASE + n*BYTE_W +: BYTE_W] = q_s[n];
      end
      return w_s;
   endfunction

   function automatic logic [1:0] first_sync(input logic [3:0] sync_s);
      logic [1:0] lane_s;
      casez (sync_s)
         4'b???1: lane_s = 2'd0;
         4'b??10: lane_s = 2'd1;
         4'b?100: lane_s = 2'd2;
         4'b1000: lane_s = 2'd3;
         default: lane_s = 2'd0;
      endcase
      return lane_s;
   endfunction

endpackage

// File: rtl/katadc_snap_ram.sv
// Simple dual-port snapshot buffer: one write port, one registered read-first
// read port, single clock. Contents are never reset.
module katadc_snap_ram
   import katadc_snapshot_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [63:0]       wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [63:0]       rd_data
);

   logic [63:0] mem_r [2**ADDR_W];

   // storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // registered read; a same-cycle write to this address shows its old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= 64'd0;
      end else begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/katadc_snapshot.sv
// Triggered snapshot capture of KAT ADC words into an on-chip buffer, with
// status (count, trigger lane, overrange count) for software readback.
module katadc_snapshot
   import katadc_snapshot_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int OR_CNT_W = 16
) (
   input  logic                ctrl_clk_in,
   input  logic                ctrl_reset,
   input  logic [7:0]          user_datai0,
   input  logic [7:0]          user_datai1,
   input  logic [7:0]          user_datai2,
   input  logic [7:0]          user_datai3,
   input  logic [7:0]          user_dataq0,
   input  logic [7:0]          user_dataq1,
   input  logic [7:0]          user_dataq2,
   input  logic [7:0]          user_dataq3,
   input  logic                user_sync0,
   input  logic                user_sync1,
   input  logic                user_sync2,
   input  logic                user_sync3,
   input  logic                user_outofrange0,
   input  logic                user_outofrange1,
   input  logic                user_data_valid,
   input  logic                snap_arm,
   input  logic                snap_trig_sel,
   input  logic [ADDR_W-1:0]   snap_len_m1,
   input  logic [ADDR_W-1:0]   snap_rd_addr,
   output logic [63:0]         snap_rd_data,
   output logic                snap_busy,
   output logic                snap_done,
   output logic [ADDR_W:0]     snap_count,
   output logic [1:0]          snap_trig_lane,
   output logic [OR_CNT_W-1:0] snap_or_count
);

   localparam logic [ADDR_W:0]     CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]     CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [OR_CNT_W-1:0] OR_ZERO  = {OR_CNT_W{1'b0}};
   localparam logic [OR_CNT_W-1:0] OR_ONE   = {{(OR_CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [OR_CNT_W-1:0] sat_inc(input logic [OR_CNT_W-1:0] v_s);
      return (&v_s) ? v_s : v_s + OR_ONE;
   endfunction

   snap_state_t         state_r, state_s;
   logic                trig_sel_r, trig_sel_s;
   logic [ADDR_W-1:0]   len_m1_r, len_m1_s;
   logic [ADDR_W:0]     count_r, count_s;
   logic [1:0]          lane_r, lane_s;
   logic [OR_CNT_W-1:0] or_cnt_r, or_cnt_s;
   logic                busy_r, done_r;
   logic                we_s;
   logic [ADDR_W-1:0]   wr_addr_s;
   logic [63:0]         wr_data_s;
   logic [3:0]          sync_s;
   logic                or_any_s;

   assign sync_s    = {user_sync3, user_sync2, user_sync1, user_sync0};
   assign or_any_s  = user_outofrange0 | user_outofrange1;
   assign wr_data_s = pack_word({user_datai3, user_datai2, user_datai1, user_datai0},
                                {user_dataq3, user_dataq2, user_dataq1, user_dataq0});

   // next-state, status updates and buffer write control; arm takes priority
   always_comb begin
      state_s    = state_r;
      trig_sel_s = trig_sel_r;
      len_m1_s   = len_m1_r;
      count_s    = count_r;
      lane_s     = lane_r;
      or_cnt_s   = or_cnt_r;
      we_s       = 1'b0;
      wr_addr_s  = count_r[ADDR_W-1:0];
      if (snap_arm) begin
         state_s    = ST_ARMED;
         trig_sel_s = snap_trig_sel;
         len_m1_s   = snap_len_m1;
         count_s    = CNT_ZERO;
         lane_s     = 2'd0;
         or_cnt_s   = OR_ZERO;
      end else begin
         case (state_r)
            ST_ARMED: begin
               if (user_data_valid && (!trig_sel_r || (|sync_s))) begin
                  we_s      = 1'b1;
                  wr_addr_s = {ADDR_W{1'b0}};
                  count_s   = CNT_ONE;
                  lane_s    = trig_sel_r ? first_sync(sync_s) : 2'd0;
                  or_cnt_s  = or_any_s ? sat_inc(or_cnt_r) : or_cnt_r;
                  state_s   = (len_m1_r == {ADDR_W{1'b0}}) ? ST_DONE : ST_CAPTURE;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_CAPTURE: begin
               if (user_data_valid) begin
                  we_s     = 1'b1;
                  count_s  = count_r + CNT_ONE;
                  or_cnt_s = or_any_s ? sat_inc(or_cnt_r) : or_cnt_r;
                  state_s  = ({1'b0, len_m1_r} == count_r) ? ST_DONE : ST_CAPTURE;
               end else begin
                  state_s = ST_CAPTURE;
               end
            end
            ST_IDLE: state_s = ST_IDLE;
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // state and status registers
   always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         state_r    <= ST_IDLE;
         trig_sel_r <= 1'b0;
         len_m1_r   <= {ADDR_W{1'b0}};
         count_r    <= CNT_ZERO;
         lane_r     <= 2'd0;
         or_cnt_r   <= OR_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         trig_sel_r <= trig_sel_s;
         len_m1_r   <= len_m1_s;
         count_r    <= count_s;
         lane_r     <= lane_s;
         or_cnt_r   <= or_cnt_s;
         busy_r     <= (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
         done_r     <= (state_s == ST_DONE);
      end
   end

   assign snap_busy      = busy_r;
   assign snap_done      = done_r;
   assign snap_count     = count_r;
   assign snap_trig_lane = lane_r;
   assign snap_or_count  = or_cnt_r;

   katadc_snap_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (ctrl_clk_in),
      .rst     (ctrl_reset),
      .we      (we_s),
      .wr_addr (wr_addr_s),
      .wr_data (wr_data_s),
      .rd_addr (snap_rd_addr),
      .rd_data (snap_rd_data)
   );

endmodule

// File: tb/tb_katadc_snapshot.sv
// Directed self-checking bench for katadc_snapshot.
module tb_katadc_snapshot;

   localparam int ADDR_W   = 10;
   localparam int OR_CNT_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [7:0]          di0, di1, di2, di3, dq0, dq1, dq2, dq3;
   logic                s0, s1, s2, s3, or0, or1, valid;
   logic                arm, trig_sel;
   logic [ADDR_W-1:0]   len_m1, rd_addr;
   logic [63:0]         rd_data;
   logic                busy, done;
   logic [ADDR_W:0]     count;
   logic [1:0]          lane;
   logic [OR_CNT_W-1:0] or_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   katadc_snapshot #(.ADDR_W(ADDR_W), .OR_CNT_W(OR_CNT_W)) dut (
      .ctrl_clk_in(clk), .ctrl_reset(rst),
      .user_datai0(di0), .user_datai1(di1), .user_datai2(di2), .user_datai3(di3),
      .user_dataq0(dq0), .user_dataq1(dq1), .user_dataq2(dq2), .user_dataq3(dq3),
      .user_sync0(s0), .user_sync1(s1), .user_sync2(s2), .user_sync3(s3),
      .user_outofrange0(or0), .user_outofrange1(or1), .user_data_valid(valid),
      .snap_arm(arm), .snap_trig_sel(trig_sel), .snap_len_m1(len_m1),
      .snap_rd_addr(rd_addr), .snap_rd_data(rd_data),
      .snap_busy(busy), .snap_done(done), .snap_count(count),
      .snap_trig_lane(lane), .snap_or_count(or_count)
   );

   // distinct test word: lane n of I = 4k+n, Q = that value xor A5
   function automatic logic [63:0] w(input int k);
      logic [63:0] r;
      logic [7:0]  b;
      r = 64'd0;
      for (int n = 0; n < 4; n++) begin
         b = 8'(k*4 + n);
         r[8*n +: 8]      = b;
         r[32 + 8*n +: 8] = b ^ 8'hA5;
      end
      return r;
   endfunction

   task automatic drive(input logic [63:0] d, input logic v, input logic [3:0] s,
                        input logic [1:0] o);
      {dq3, dq2, dq1, dq0, di3, di2, di1, di0} = d;
      valid = v;
      {s3, s2, s1, s0} = s;
      {or1, or0} = o;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int a, input logic [63:0] exp);
      rd_addr = ADDR_W'(a);
      tick();
      chk($sformatf("rd[%0d]", a), rd_data, exp);
   endtask

   task automatic do_arm(input logic ts, input int lm1);
      arm = 1'b1;
      trig_sel = ts;
      len_m1 = ADDR_W'(lm1);
      tick();
      arm = 1'b0;
   endtask

   initial begin
      arm = 1'b0; trig_sel = 1'b0; len_m1 = '0; rd_addr = '0;
      drive(64'd0, 1'b0, 4'b0000, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      rst = 1'b0;
      tick();
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_lane", 64'(lane), 64'd0);
      chk("idle_or", 64'(or_count), 64'd0);

      // 1: immediate trigger, 8 contiguous words; arm-cycle data not written
      drive(w(127), 1'b1, 4'b0000, 2'b00);
      do_arm(1'b0, 7);
      chk("t1_armed_busy", 64'(busy), 64'd1);
      chk("t1_armed_count", 64'(count), 64'd0);
      for (int k = 0; k < 8; k++) begin
         drive(w(k), 1'b1, 4'b0000, 2'b00);
         tick();
      end
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_busy", 64'(busy), 64'd0);
      chk("t1_count", 64'(count), 64'd8);
      drive(w(9), 1'b1, 4'b0000, 2'b00);
      tick();
      chk("t1_done_hold", 64'(count), 64'd8);
      for (int k = 0; k < 8; k++) rd(k, w(k));

      // 2: sync trigger; lowest sync lane wins, sync without valid ignored
      drive(64'd0, 1'b0, 4'b0000, 2'b00);
      do_arm(1'b1, 3);
      for (int c = 1; c < 20; c++) begin
         drive(w(16 + c), 1'b1, 4'b0000, 2'b00);
         tick();
      end
      chk("t2_wait_busy", 64'(busy), 64'd1);
      chk("t2_wait_count", 64'(count), 64'd0);
      drive(w(16), 1'b0, 4'b0001, 2'b00);
      tick();
      chk("t2_novalid_count", 64'(count), 64'd0);
      drive(w(32), 1'b1, 4'b1100, 2'b00);
      tick();
      chk("t2_trig_count", 64'(count), 64'd1);
      chk("t2_trig_lane", 64'(lane), 64'd2);
      for (int k = 33; k < 36; k++) begin
         drive(w(k), 1'b1, 4'b0001, 2'b00);
         tick();
      end
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_count", 64'(count), 64'd4);
      chk("t2_lane_hold", 64'(lane), 64'd2);
      rd(0, w(32));
      rd(3, w(35));

      // 3: valid toggling, only valid words stored
      do_arm(1'b0, 3);
      for (int i = 0; i < 6; i++) begin
         drive(w(48 + i), (i % 2) == 0, 4'b0000, 2'b00);
         tick();
      end
      chk("t3_count_mid", 64'(count), 64'd3);
      chk("t3_busy_mid", 64'(busy), 64'd1);
      drive(w(54), 1'b1, 4'b0000, 2'b00);
      tick();
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_count", 64'(count), 64'd4);
      for (int k = 0; k < 4; k++) rd(k, w(48 + 2*k));

      // 4: overrange every cycle saturates the 4-bit counter
      do_arm(1'b0, 31);
      for (int c = 0; c < 10; c++) begin
         drive(w(64 + c), 1'b1, 4'b0000, (c % 2) ? 2'b10 : 2'b01);
         tick();
      end
      chk("t4_or_mid", 64'(or_count), 64'd10);
      for (int c = 10; c < 32; c++) begin
         drive(w(64 + c), 1'b1, 4'b0000, (c % 2) ? 2'b10 : 2'b01);
         tick();
      end
      chk("t4_or_sat", 64'(or_count), 64'd15);
      chk("t4_count", 64'(count), 64'd32);
      chk("t4_done", 64'(done), 64'd1);

      // 5: re-arm mid-capture clears status and restarts at address 0
      do_arm(1'b0, 7);
      for (int k = 0; k < 5; k++) begin
         drive(w(80 + k), 1'b1, 4'b0000, 2'b01);
         tick();
      end
      chk("t5_pre_count", 64'(count), 64'd5);
      chk("t5_pre_or", 64'(or_count), 64'd5);
      drive(w(112), 1'b1, 4'b0000, 2'b01);
      do_arm(1'b0, 1);
      chk("t5_rearm_count", 64'(count), 64'd0);
      chk("t5_rearm_or", 64'(or_count), 64'd0);
      chk("t5_rearm_busy", 64'(busy), 64'd1);
      for (int k = 0; k < 2; k++) begin
         drive(w(96 + k), 1'b1, 4'b0000, 2'b00);
         tick();
      end
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_count", 64'(count), 64'd2);
      rd(0, w(96));
      rd(1, w(97));
      rd(2, w(82));
      rd(5, w(69));

      // 6: async reset mid-capture
      do_arm(1'b0, 15);
      for (int k = 0; k < 3; k++) begin
         drive(w(144 + k), 1'b1, 4'b0000, 2'b01);
         tick();
      end
      chk("t6_pre_count", 64'(count), 64'd3);
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_count", 64'(count), 64'd0);
      chk("t6_rst_or", 64'(or_count), 64'd0);
      chk("t6_rst_rd_data", rd_data, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_count", 64'(count), 64'd0);
      for (int k = 0; k < 3; k++) rd(k, w(144 + k));
      rd(3, w(83));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
